dbg_bus_bridge: RTL
===================

DBG_BUS_BRIDGE -- requirements
Module: dbg_bus_bridge

Interface
REQ-001 SHALL have parameter DBG_BASE, default 32'h2000_0000; bits [31:24] select the debug region.
REQ-002 SHALL have parameter DEPTH, default 8; the number of FIFO entries; legal values are powers of two ≥2.
REQ-003 SHALL have parameter BLOCKING, default 1; 1 = stall the CPU when full, 0 = drop the write when full.
REQ-004 SHALL have one clock, clk_i; reset is asynchronous and active-low, named rst_ni.
REQ-005 clk_i  in  1  system clock.
REQ-006 rst_ni  in  1  asynchronous active-low reset.
REQ-007 cpu_en_i  in  1  CPU data-bus access valid.
REQ-008 cpu_we_i  in  1  access is a write.
REQ-009 cpu_addr_i  in  32  byte address.
REQ-010 cpu_data_i  in  32  write data.
REQ-011 cpu_gnt_o  out  1  access accepted this cycle.
REQ-012 tick_cntr_i  in  64  free-running tick counter.
REQ-013 dbg_en_o / dbg_we_o  out  1  downstream write strobe; both are always equal.
REQ-014 dbg_addr_o  out  24  debug register offset (cpu_addr_i[23:0]).
REQ-015 dbg_data_o  out  32  write data.
REQ-016 dbg_tick_o  out  64  timestamp captured at acceptance.
REQ-017 dbg_ready_i  in  1  sink consumes the head entry this cycle.
REQ-018 level_o  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 drop_cnt_o  out  16  dropped-write count; saturates at 16'hFFFF.

Function
REQ-020 hit SHALL = cpu_en_i & cpu_we_i & (cpu_addr_i[31:24]==DBG_BASE[31:24]); reads and out-of-region accesses are never stored.
REQ-021 cpu_gnt_o SHALL = ~(hit & full & BLOCKING), combinationally; all non-hit accesses are granted.
REQ-022 A push SHALL occur when hit & ~full, storing {addr[23:0], data, tick_cntr_i} sampled in that cycle.
REQ-023 When full, a hit SHALL not push, even if a pop occurs in the same cycle; full is evaluated before the pop.
REQ-024 A pop SHALL occur when dbg_en_o & dbg_ready_i.
REQ-025 dbg_en_o SHALL = ~empty; the dbg_addr_o, dbg_data_o and dbg_tick_o outputs present the head entry; data outputs are don't-care when empty.
REQ-026 Latency: an entry pushed at cycle N SHALL appear on the outputs at cycle N+1 at the earliest; there is no fall-through in the same cycle.
REQ-027 Push and pop in the same cycle SHALL leave level_o unchanged.
REQ-028 Entries SHALL be delivered in strict FIFO order, with no loss or duplication.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL use an extra pointer MSB.
REQ-030 With BLOCKING=0, a hit while full SHALL be granted, discarded, and SHALL increment drop_cnt_o by 1, saturating.
REQ-031 With BLOCKING=1, drop_cnt_o SHALL stay 0.
REQ-032 dbg_ready_i while empty SHALL have no effect.

Reset
REQ-033 While rst_ni=0 SHALL set: pointers=0, level_o=0, dbg_en_o=dbg_we_o=0, drop_cnt_o=0; reset takes effect asynchronously.
REQ-034 Reset mid-operation SHALL discard all buffered entries; no partial entry is emitted after release.
REQ-035 Storage RAM contents SHALL not require reset.

Verification
REQ-036 Single write: addr 32'h2000_0010, data 5, tick 100, ready=1 -> next cycle dbg_en_o=1, addr 24'h000010, data 5, tick 100; the cycle after, dbg_en_o=0.
REQ-037 Fill with ready=0, DEPTH=8 writes -> level_o=8; 9th write sees cpu_gnt_o=0 until ready=1 pops one; order of the 8 outputs matches the inputs.
REQ-038 Full plus simultaneous hit and ready=1 -> pop occurs, no push, level_o=7, cpu_gnt_o=0 in that cycle.
REQ-039 BLOCKING=0, full, 3 more hits -> cpu_gnt_o=1 each, drop_cnt_o=3, FIFO contents unchanged.
REQ-040 Read of 32'h2000_0004 and write of 32'h1000_0000 -> both granted, level_o stays 0.
REQ-041 Assert rst_ni=0 with 5 entries buffered -> dbg_en_o=0 and level_o=0 immediately; after release, a new write appears normally.

Source files
------------

// File: rtl/dbg_bus_bridge_if.sv
// dbg_bus_bridge_if: CPU-side write bus and downstream debug sink bus of the bridge
interface dbg_bus_bridge_if;
  logic        cpu_en_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic        cpu_gnt_o;
  logic [63:0] tick_cntr_i;
  logic        dbg_en_o;
  logic        dbg_we_o;
  logic [23:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [63:0] dbg_tick_o;
  logic        dbg_ready_i;
  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, tick_cntr_i, dbg_ready_i,
    output cpu_gnt_o, dbg_en_o, dbg_we_o, dbg_addr_o, dbg_data_o, dbg_tick_o
  );
  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i, tick_cntr_i, dbg_ready_i,
    input  cpu_gnt_o, dbg_en_o, dbg_we_o, dbg_addr_o, dbg_data_o, dbg_tick_o
  );
endinterface

// File: rtl/dbg_bus_bridge.sv
// dbg_bus_bridge: queues timestamped CPU writes to the debug region for a downstream sink
module dbg_bus_bridge #(
  parameter logic [31:0] DBG_BASE = 32'h2000_0000,
  parameter int          DEPTH    = 8,
  parameter bit          BLOCKING = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  dbg_bus_bridge_if.slave        bus,
  output logic [$clog2(DEPTH):0] level_o,
  output logic [15:0]            drop_cnt_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]   wp, rp;
  logic [119:0]  mem [DEPTH];
  logic          hit, full, empty, push, pop;
  always_comb begin
    hit            = bus.cpu_en_i & bus.cpu_we_i & (bus.cpu_addr_i[31:24] == DBG_BASE[31:24]);
    empty          = wp == rp;
    full           = (wp[AW-1:0] == rp[AW-1:0]) & (wp[AW] != rp[AW]);
    push           = hit & ~full;
    pop            = ~empty & bus.dbg_ready_i;
    bus.cpu_gnt_o  = ~(hit & full & BLOCKING);
    bus.dbg_en_o   = ~empty;
    bus.dbg_we_o   = ~empty;
    {bus.dbg_addr_o, bus.dbg_data_o, bus.dbg_tick_o} = mem[rp[AW-1:0]];
    level_o        = wp - rp;
  end
  always_ff @(posedge clk_i)
    if (push) mem[wp[AW-1:0]] <= {bus.cpu_addr_i[23:0], bus.cpu_data_i, bus.tick_cntr_i};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop) rp <= rp + (AW+1)'(1);
    end
  // Only a non-blocking bridge ever discards, so the counter stays 0 otherwise.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) drop_cnt_o <= '0;
    else if (!BLOCKING && hit && full && drop_cnt_o != 16'hFFFF) drop_cnt_o <= drop_cnt_o + 16'd1;
endmodule
